// File: rtl/cs_decoder_ws_pkg.sv
// Shared definitions for the wait-state chip-select decoder: state encoding
// and small constant helpers used to size counters.
package cs_decoder_ws_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  // Bits needed to hold values 0 .. value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cs_decoder_ws_onehot_dec.sv
// Combinational select-to-active-low one-hot decoder with a gate input.
// Gate low forces every output high.
module cs_onehot_dec #(
  parameter int SEL_W = 3,
  localparam int NCS = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             gate,
  output logic [NCS-1:0]   cs_n
);

  // Drive exactly one line low when gated on, otherwise all high.
  always_comb begin
    cs_n = '1;
    if (gate) cs_n[sel] = 1'b0;
  end

endmodule

// File: rtl/cs_decoder_ws.sv
// Clocked chip-select decoder with per-channel programmable wait states,
// a one-cycle completion ack, an abort path on loss of enable, and a
// bus-turnaround gap.
//
// Handshake: a request is accepted on a rising edge where the FSM is idle
// and stb and en are both high; stb at any other time is dropped, never
// queued. Completion is signalled by a single-cycle ack; an en drop during
// the strobe ends it early with a single-cycle abort instead of ack.
module cs_decoder_ws
  import cs_decoder_ws_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int WS_W  = 4,
  parameter int TURN  = 1,
  localparam int NCS  = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stb,
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  input  logic [NCS*WS_W-1:0] ws_cfg,
  output logic [NCS-1:0]    cs_n,
  output logic              ack,
  output logic              abort,
  output logic              busy,
  output logic [ST_W-1:0]   fsm_state
);

  localparam int CNT_W = max_int(WS_W, clog2(TURN + 1));
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel_q;
  logic              accept;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_gate;
  logic [NCS-1:0]    dec_cs_n;
  logic [CNT_W-1:0]  ws_load;

  assign accept    = (state == ST_IDLE) && stb && en;
  assign ws_load   = CNT_W'(ws_cfg[sel*WS_W +: WS_W]);
  assign fsm_state = state;

  // Decode the live select while idle, the latched one while the strobe runs.
  always_comb begin
    dec_sel  = sel_q;
    dec_gate = 1'b0;
    if (state == ST_IDLE) begin
      dec_sel  = sel;
      dec_gate = accept;
    end else if (state == ST_ACTIVE) begin
      dec_gate = en;
    end
  end

  cs_onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel  (dec_sel),
    .gate (dec_gate),
    .cs_n (dec_cs_n)
  );

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= '0;
      cs_n  <= '1;
      ack   <= 1'b0;
      abort <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack   <= 1'b0;
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sel_q <= sel;
            cnt   <= ws_load;
            cs_n  <= dec_cs_n;
            busy  <= 1'b1;
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE, ST_ACK: begin
          if (!en || state == ST_ACK) begin
            // Strobe ends: either abort or the cycle after ack.
            cs_n  <= '1;
            abort <= !en;
            if (TURN > 0) begin
              cnt   <= TURN_LOAD;
              state <= ST_RECOVER;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            cs_n <= dec_cs_n;
          end else begin
            ack   <= 1'b1;
            cs_n  <= dec_cs_n;
            state <= ST_ACK;
          end
        end
        ST_RECOVER: begin
          cs_n <= '1;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_decoder_ws.sv
// Directed bench for cs_decoder_ws: one instance with TURN=1, one with TURN=0.
module tb_cs_decoder_ws;

  logic        clk;
  logic        reset;
  logic [31:0] ws_cfg;

  logic       stb1, en1;
  logic [2:0] sel1;
  logic [7:0] cs_n1;
  logic       ack1, abort1, busy1;
  logic [1:0] st1;

  logic       stb0, en0;
  logic [2:0] sel0;
  logic [7:0] cs_n0;
  logic       ack0, abort0, busy0;
  logic [1:0] st0;

  int checks;
  int errors;
  int ack_cnt1, abort_cnt1, ack_cnt0;

  cs_decoder_ws #(.SEL_W(3), .WS_W(4), .TURN(1)) dut1 (
    .clk(clk), .reset(reset), .stb(stb1), .sel(sel1), .en(en1), .ws_cfg(ws_cfg),
    .cs_n(cs_n1), .ack(ack1), .abort(abort1), .busy(busy1), .fsm_state(st1)
  );

  cs_decoder_ws #(.SEL_W(3), .WS_W(4), .TURN(0)) dut0 (
    .clk(clk), .reset(reset), .stb(stb0), .sel(sel0), .en(en0), .ws_cfg(ws_cfg),
    .cs_n(cs_n0), .ack(ack0), .abort(abort0), .busy(busy0), .fsm_state(st0)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] cs, input logic a, input logic ab,
                      input logic b, input logic [7:0] e_cs, input logic e_a,
                      input logic e_ab, input logic e_b);
    chk({tag, "_cs"}, cs, e_cs);
    chk({tag, "_ack"}, {7'b0, a}, {7'b0, e_a});
    chk({tag, "_abort"}, {7'b0, ab}, {7'b0, e_ab});
    chk({tag, "_busy"}, {7'b0, b}, {7'b0, e_b});
  endtask

  // Invariants and pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    checks++;
    assert ($countones(~cs_n1) <= 1 && $countones(~cs_n0) <= 1 &&
            !(ack1 && abort1) && !(ack0 && abort0)) else begin
      errors++;
      $error("FAIL invariant observed cs1=%h cs0=%h a1=%b ab1=%b a0=%b ab0=%b expected onehot/exclusive",
             cs_n1, cs_n0, ack1, abort1, ack0, abort0);
    end
    if (ack1) ack_cnt1++;
    if (abort1) abort_cnt1++;
    if (ack0) ack_cnt0++;
  end

  initial begin
    checks = 0; errors = 0; ack_cnt1 = 0; abort_cnt1 = 0; ack_cnt0 = 0;
    reset = 1'b1;
    stb1 = 1'b0; en1 = 1'b1; sel1 = 3'd0;
    stb0 = 1'b0; en0 = 1'b1; sel0 = 3'd0;
    ws_cfg = '0;
    ws_cfg[0*4 +: 4] = 4'd1;
    ws_cfg[2*4 +: 4] = 4'd7;
    ws_cfg[3*4 +: 4] = 4'd0;
    ws_cfg[5*4 +: 4] = 4'd3;
    ws_cfg[6*4 +: 4] = 4'd4;
    ws_cfg[7*4 +: 4] = 4'd1;
    tick; tick;
    chk1("reset_hold", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);
    reset = 1'b0;
    tick;
    chk("reset_state", {6'b0, st1}, 8'd0);
    chk("reset_cs0", cs_n0, 8'hFF);

    // Basic decode: sel 3, ws 0
    stb1 = 1'b1; sel1 = 3'd3;
    tick;
    stb1 = 1'b0;
    chk1("basic_c1", cs_n1, ack1, abort1, busy1, 8'hF7, 0, 0, 1);
    tick;
    chk1("basic_c2", cs_n1, ack1, abort1, busy1, 8'hF7, 1, 0, 1);
    tick;
    chk1("basic_turn", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 1);
    tick;
    chk1("basic_idle", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);

    // Wait states: sel 6, ws 4, sel changes to 1 mid-transaction
    stb1 = 1'b1; sel1 = 3'd6;
    tick;
    stb1 = 1'b0; sel1 = 3'd1;
    chk1("ws_c1", cs_n1, ack1, abort1, busy1, 8'hBF, 0, 0, 1);
    for (int i = 2; i <= 5; i++) begin
      tick;
      chk1("ws_mid", cs_n1, ack1, abort1, busy1, 8'hBF, 0, 0, 1);
    end
    tick;
    chk1("ws_c6", cs_n1, ack1, abort1, busy1, 8'hBF, 1, 0, 1);
    tick;
    chk1("ws_turn", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 1);
    tick;
    chk1("ws_idle", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);

    // Abort: sel 2, ws 7, en dropped for the edge starting the 3rd cs cycle
    stb1 = 1'b1; sel1 = 3'd2;
    tick;
    stb1 = 1'b0;
    chk1("abort_c1", cs_n1, ack1, abort1, busy1, 8'hFB, 0, 0, 1);
    tick;
    chk1("abort_c2", cs_n1, ack1, abort1, busy1, 8'hFB, 0, 0, 1);
    en1 = 1'b0;
    tick;
    en1 = 1'b1;
    chk1("abort_edge", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 1, 1);
    chk("abort_state", {6'b0, st1}, 8'd3);
    tick;
    chk1("abort_idle", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);

    // Blocked: stb with en low
    en1 = 1'b0; stb1 = 1'b1; sel1 = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk1("blocked", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);
    end
    stb1 = 1'b0; en1 = 1'b1;

    // Back-to-back on TURN=0 instance: sel 0 then 7, ws 1 each
    stb0 = 1'b1; sel0 = 3'd0;
    tick;
    chk1("b2b_a1", cs_n0, ack0, abort0, busy0, 8'hFE, 0, 0, 1);
    tick;
    sel0 = 3'd7;
    chk1("b2b_a2", cs_n0, ack0, abort0, busy0, 8'hFE, 0, 0, 1);
    tick;
    chk1("b2b_a3", cs_n0, ack0, abort0, busy0, 8'hFE, 1, 0, 1);
    tick;
    chk1("b2b_gap", cs_n0, ack0, abort0, busy0, 8'hFF, 0, 0, 0);
    tick;
    stb0 = 1'b0;
    chk1("b2b_b1", cs_n0, ack0, abort0, busy0, 8'h7F, 0, 0, 1);
    tick;
    chk1("b2b_b2", cs_n0, ack0, abort0, busy0, 8'h7F, 0, 0, 1);
    tick;
    chk1("b2b_b3", cs_n0, ack0, abort0, busy0, 8'h7F, 1, 0, 1);
    tick;
    chk1("b2b_end", cs_n0, ack0, abort0, busy0, 8'hFF, 0, 0, 0);

    // Boundary: ws 15 on channel 0 gives a 17-cycle strobe
    ws_cfg[0*4 +: 4] = 4'd15;
    stb1 = 1'b1; sel1 = 3'd0;
    tick;
    stb1 = 1'b0;
    chk1("ws15_c1", cs_n1, ack1, abort1, busy1, 8'hFE, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk1("ws15_run", cs_n1, ack1, abort1, busy1, 8'hFE, (k == 16), 0, 1);
    end
    tick;
    chk1("ws15_end", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 1);
    tick;
    chk("ws15_idle", {6'b0, st1}, 8'd0);

    // Asynchronous reset mid-ACTIVE on channel 5
    stb1 = 1'b1; sel1 = 3'd5;
    tick;
    stb1 = 1'b0;
    chk1("rst_c1", cs_n1, ack1, abort1, busy1, 8'hDF, 0, 0, 1);
    tick;
    #2;
    reset = 1'b1;
    #1;
    chk1("rst_async", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);
    chk("rst_async_state", {6'b0, st1}, 8'd0);
    reset = 1'b0;
    tick;
    chk1("rst_after", cs_n1, ack1, abort1, busy1, 8'hFF, 0, 0, 0);
    chk("rst_after_state", {6'b0, st1}, 8'd0);

    // Pulse totals
    chk("ack_total1", ack_cnt1[7:0], 8'd3);
    chk("abort_total1", abort_cnt1[7:0], 8'd1);
    chk("ack_total0", ack_cnt0[7:0], 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
